gpio_in_reader: RTL

- Input-direction counterpart to the board LED output path: samples WIDTH board pins (PMOD/push-buttons), synchronises and debounces them, and latches rising/falling edge events.
- Exposes state, events and interrupt enables to attosoc over its native valid/ready memory bus.
- The top-level address decoder drives mem_sel; pins arrive from IBUFCTRL outputs.

---
 rtl/gpio_in_pkg.sv | 34 +++
 rtl/gpio_debounce.sv | 72 +++++++
 rtl/gpio_in_reader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/gpio_in_pkg.sv
// Shared constants and types for the GPIO input reader (register offsets, bus FSM states).
// Latency: n/a (package only).
// Backpressure: n/a. Build macro GPIO_IN_INVERT_EN widens the bus address for the INVERT register.
package gpio_in_pkg;

  // Byte offsets of the software-visible registers.
  localparam logic [4:0] REG_STATE  = 5'h00;
  localparam logic [4:0] REG_RISE   = 5'h04;
  localparam logic [4:0] REG_FALL   = 5'h08;
  localparam logic [4:0] REG_IRQ_EN = 5'h0C;
  localparam logic [4:0] REG_INVERT = 5'h10;

`ifdef GPIO_IN_INVERT_EN
  localparam int ADDR_W = 5;
`else
  localparam int ADDR_W = 4;
`endif

  // Bus handshake: one request is served, then one cycle of turnaround.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } bus_state_e;

  // Expand byte strobes into a 32-bit bit-enable mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One-bit synchroniser + debouncer: 2-flop sync, then a level commits after DEBOUNCE_CYCLES stable cycles.
// Latency: 2 + DEBOUNCE_CYCLES clk edges from the first edge that sees a new pin level.
// Backpressure: none; rise_o/fall_o are single-cycle pulses issued in the cycle before level_o updates.
module gpio_debounce
  import gpio_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
`ifdef GPIO_IN_INVERT_EN
  input  logic inv_i,
`endif
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl;

  // Sync chain shift, optional polarity flip, and stability counter.
  always_comb begin
    s1_d     = pin_i;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_o   = 1'b0;
    fall_o   = 1'b0;
`ifdef GPIO_IN_INVERT_EN
    lvl      = s2_q ^ inv_i;
`else
    lvl      = s2_q;
`endif
    if (lvl == stable_q) begin
      // Any return to the committed level restarts the count, so glitches vanish.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = lvl;
      cnt_d    = '0;
      rise_o   = lvl;
      fall_o   = ~lvl;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers; the counter stops at CNT_LAST so it cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;

endmodule

// File: rtl/gpio_in_reader.sv
// Debounced GPIO input block: per-pin debounce, sticky RISE/FALL flags, IRQ enables, valid/ready register bus.
// Latency: request sampled at edge N -> mem_ready/mem_rdata valid for cycle N+1 only; irq lags flags by 1 cycle.
// Backpressure: one request per two cycles (IDLE/ACK); requests during ACK wait until IDLE. Macro GPIO_IN_INVERT_EN adds INVERT at 0x10.
module gpio_in_reader
  import gpio_in_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  pins_i,
  input  logic              mem_sel,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              irq
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise_p;
  logic [WIDTH-1:0] fall_p;

  bus_state_e       state_q, state_d;
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic             irq_q, irq_d;
`ifdef GPIO_IN_INVERT_EN
  logic [WIDTH-1:0] invert_q, invert_d;
`endif

  logic [4:0]       off;
  logic [31:0]      wmask32;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wbits;
  logic [31:0]      rd_val;
  logic             unused_ok;

  // Address low bits and write-data bits above WIDTH carry no information here.
  assign unused_ok = ^{mem_addr, mem_wdata, wmask32};

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .pin_i   (pins_i[i]),
`ifdef GPIO_IN_INVERT_EN
      .inv_i   (invert_q[i]),
`endif
      .level_o (level[i]),
      .rise_o  (rise_p[i]),
      .fall_o  (fall_p[i])
    );
  end

  // Address decode, byte-lane masking and read mux over the current register values.
  always_comb begin
    off                  = '0;
    off[ADDR_W-1:2]      = mem_addr[ADDR_W-1:2];
    wmask32              = strb_mask(mem_wstrb);
    wmask                = wmask32[WIDTH-1:0];
    wbits                = mem_wdata[WIDTH-1:0] & wmask;
    rd_val               = '0;
    case (off)
      REG_STATE:  rd_val[WIDTH-1:0] = level;
      REG_RISE:   rd_val[WIDTH-1:0] = rise_q;
      REG_FALL:   rd_val[WIDTH-1:0] = fall_q;
      REG_IRQ_EN: rd_val[WIDTH-1:0] = irq_en_q;
`ifdef GPIO_IN_INVERT_EN
      REG_INVERT: rd_val[WIDTH-1:0] = invert_q;
`endif
      default:    rd_val = '0;
    endcase
  end

  // Bus FSM next state, register writes, and flag/irq updates; event set beats W1C clear.
  always_comb begin
    state_d  = state_q;
    ready_d  = 1'b0;
    rdata_d  = '0;
    rise_d   = rise_q | rise_p;
    fall_d   = fall_q | fall_p;
    irq_en_d = irq_en_q;
`ifdef GPIO_IN_INVERT_EN
    invert_d = invert_q;
`endif
    irq_d    = |((rise_q | fall_q) & irq_en_q);

    case (state_q)
      IDLE: begin
        if (mem_valid && mem_sel && !ready_q) begin
          state_d = ACK;
          ready_d = 1'b1;
          if (mem_wstrb != 4'b0000) begin
            case (off)
              REG_RISE:   rise_d   = (rise_q & ~wbits) | rise_p;
              REG_FALL:   fall_d   = (fall_q & ~wbits) | fall_p;
              REG_IRQ_EN: irq_en_d = (irq_en_q & ~wmask) | wbits;
`ifdef GPIO_IN_INVERT_EN
              REG_INVERT: invert_d = (invert_q & ~wmask) | wbits;
`endif
              default:    ;
            endcase
          end else begin
            rdata_d = rd_val;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register update with synchronous reset; reset also drops any in-flight acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
`ifdef GPIO_IN_INVERT_EN
      invert_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
`ifdef GPIO_IN_INVERT_EN
      invert_q <= invert_d;
`endif
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign irq       = irq_q;

endmodule
